// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings and parameter defaults for the game sequencer
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_HIT   = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_e;

    localparam int NUM_LEVELS_DEF  = 3;
    localparam int START_LIVES_DEF = 3;
    localparam int HIT_TICKS_DEF   = 60;
    localparam int CLEAR_TICKS_DEF = 90;

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - 8-bit loadable down-counter that saturates at zero and flags its last tick
module tick_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic [7:0] count_o,
    output logic       done_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load on the same tick as a decrement wins, so entry values are exact.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == 8'd1);

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - frame-paced game flow FSM: lives, levels, hit freeze and level-clear pause
module game_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS  = NUM_LEVELS_DEF,
    parameter int START_LIVES = START_LIVES_DEF,
    parameter int HIT_TICKS   = HIT_TICKS_DEF,
    parameter int CLEAR_TICKS = CLEAR_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_tick,
    input  logic       start_btn,
    input  logic       hit_enemy,
    input  logic       hit_hazard,
    input  logic       goal_reached,
    output logic [1:0] level,
    output logic       freeze,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       respawn,
    output logic       game_won
);

    state_e     state_q, state_d;
    logic [1:0] level_q, level_d;
    logic [1:0] lives_q, lives_d;
    logic       start_prev_q;
    logic       respawn_q, respawn_d;
    logic       timer_load;
    logic [7:0] timer_val;
    logic [7:0] timer_count;
    logic       timer_done;
    logic       start_edge;
    logic       hit;

    assign start_edge = start_btn & ~start_prev_q;
    assign hit        = hit_enemy | hit_hazard;

    tick_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .dec_i     (game_tick),
        .count_o   (timer_count),
        .done_o    (timer_done)
    );

    // start_prev resets high so a button held through reset cannot start a game.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            level_q      <= 2'd0;
            lives_q      <= 2'(START_LIVES);
            start_prev_q <= 1'b1;
            respawn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            lives_q   <= lives_d;
            respawn_q <= respawn_d;
            if (game_tick) begin
                start_prev_q <= start_btn;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        lives_d    = lives_q;
        respawn_d  = 1'b0;
        timer_load = 1'b0;
        timer_val  = 8'd0;
        if (game_tick) begin
            case (state_q)
                ST_IDLE: begin
                    level_d = 2'd0;
                    lives_d = 2'(START_LIVES);
                    if (start_edge) begin
                        state_d   = ST_PLAY;
                        respawn_d = 1'b1;
                    end
                end
                ST_PLAY: begin
                    // A hit outranks a simultaneous goal.
                    if (hit) begin
                        if (lives_q <= 2'd1) begin
                            lives_d = 2'd0;
                            state_d = ST_OVER;
                        end else begin
                            lives_d    = lives_q - 2'd1;
                            timer_load = 1'b1;
                            timer_val  = 8'(HIT_TICKS);
                            state_d    = ST_HIT;
                        end
                    end else if (goal_reached) begin
                        timer_load = 1'b1;
                        timer_val  = 8'(CLEAR_TICKS);
                        state_d    = ST_CLEAR;
                    end
                end
                ST_HIT: begin
                    if (timer_done) begin
                        state_d   = ST_PLAY;
                        respawn_d = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (timer_done) begin
                        if (level_q == 2'(NUM_LEVELS - 1)) begin
                            state_d = ST_WIN;
                        end else begin
                            level_d   = level_q + 2'd1;
                            state_d   = ST_PLAY;
                            respawn_d = 1'b1;
                        end
                    end
                end
                ST_OVER, ST_WIN: begin
                    if (start_edge) begin
                        state_d = ST_IDLE;
                        level_d = 2'd0;
                        lives_d = 2'(START_LIVES);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign level    = level_q;
    assign lives    = lives_q;
    assign state    = state_q;
    assign freeze   = (state_q != ST_PLAY);
    assign respawn  = respawn_q;
    assign game_won = (state_q == ST_WIN);

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       hit_enemy = 1'b0;
    logic       hit_hazard = 1'b0;
    logic       goal_reached = 1'b0;
    logic [1:0] level;
    logic       freeze;
    logic [1:0] lives;
    logic [2:0] state;
    logic       respawn;
    logic       game_won;

    int errs   = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .game_tick   (game_tick),
        .start_btn   (start_btn),
        .hit_enemy   (hit_enemy),
        .hit_hazard  (hit_hazard),
        .goal_reached(goal_reached),
        .level       (level),
        .freeze      (freeze),
        .lives       (lives),
        .state       (state),
        .respawn     (respawn),
        .game_won    (game_won)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    task automatic tick_in(input logic he, input logic hh, input logic g);
        hit_enemy    = he;
        hit_hazard   = hh;
        goal_reached = g;
        tick();
        hit_enemy    = 1'b0;
        hit_hazard   = 1'b0;
        goal_reached = 1'b0;
    endtask

    task automatic run_out(input logic [2:0] st, output int cnt);
        cnt = 0;
        while (state == st && cnt < 300) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_level", level, 0);
        check("rst_lives", lives, 3);
        check("rst_freeze", freeze, 1);
        check("rst_respawn", respawn, 0);
        check("rst_won", game_won, 0);
        @(negedge clk);
        rst = 1'b1;

        tick();
        start_btn = 1'b1;
        tick();
        check("start_state", state, 1);
        check("start_level", level, 0);
        check("start_lives", lives, 3);
        check("start_freeze", freeze, 0);
        check("start_respawn", respawn, 1);
        @(negedge clk);
        check("start_respawn_end", respawn, 0);
        start_btn = 1'b0;
        tick();

        @(negedge clk);
        hit_enemy = 1'b1;
        goal_reached = 1'b1;
        @(negedge clk);
        hit_enemy = 1'b0;
        goal_reached = 1'b0;
        repeat (2) @(negedge clk);
        check("offtick_state", state, 1);
        check("offtick_lives", lives, 3);

        tick_in(1'b1, 1'b0, 1'b0);
        check("hit_lives", lives, 2);
        check("hit_state", state, 2);
        check("hit_freeze", freeze, 1);
        run_out(3'd2, n);
        check("hit_ticks", n, 60);
        check("hit_exit_state", state, 1);
        check("hit_exit_respawn", respawn, 1);

        tick_in(1'b1, 1'b0, 1'b1);
        check("hitgoal_state", state, 2);
        check("hitgoal_level", level, 0);
        check("hitgoal_lives", lives, 1);
        run_out(3'd2, n);
        check("hit2_ticks", n, 60);

        tick_in(1'b0, 1'b0, 1'b1);
        check("clear0_state", state, 3);
        run_out(3'd3, n);
        check("clear0_ticks", n, 90);
        check("clear0_level", level, 1);
        check("clear0_respawn", respawn, 1);
        tick_in(1'b0, 1'b0, 1'b1);
        run_out(3'd3, n);
        check("clear1_level", level, 2);
        tick_in(1'b0, 1'b0, 1'b1);
        run_out(3'd3, n);
        check("clear2_ticks", n, 90);
        check("win_state", state, 5);
        check("win_won", game_won, 1);
        check("win_freeze", freeze, 1);
        check("win_level", level, 2);

        start_btn = 1'b1;
        tick();
        check("win_idle_state", state, 0);
        check("win_idle_lives", lives, 3);
        check("win_idle_level", level, 0);
        check("win_idle_won", game_won, 0);
        tick();
        check("held_no_start", state, 0);
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        check("restart_state", state, 1);
        start_btn = 1'b0;

        tick_in(1'b1, 1'b0, 1'b0);
        run_out(3'd2, n);
        tick_in(1'b1, 1'b0, 1'b0);
        run_out(3'd2, n);
        check("last_life", lives, 1);
        tick_in(1'b0, 1'b1, 1'b0);
        check("over_lives", lives, 0);
        check("over_state", state, 4);
        tick();
        check("over_hold", state, 4);
        start_btn = 1'b1;
        tick();
        check("over_idle_state", state, 0);
        check("over_idle_lives", lives, 3);
        check("over_idle_level", level, 0);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        check("held_rst_state", state, 0);
        start_btn = 1'b0;
        tick();
        check("release_state", state, 0);
        start_btn = 1'b1;
        tick();
        check("repress_state", state, 1);
        start_btn = 1'b0;

        tick_in(1'b1, 1'b0, 1'b0);
        repeat (30) tick();
        check("midhit_state", state, 2);
        check("midhit_timer", dut.timer_count, 30);
        rst = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_freeze", freeze, 1);
        check("arst_respawn", respawn, 0);
        check("arst_lives", lives, 3);
        check("arst_timer", dut.timer_count, 0);
        @(negedge clk);
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
